escalonador_atributos: RTL and testbench
========================================

# escalonador_atributos

Periodic scheduler for the pet's three 8-bit attributes (`fome`, `felicidade`, `sono`). It sits beside `controlador_estados`: it owns the attribute registers whose values the state controller reads, and it applies `estado` on every tick. The three updates are serialized through one shared saturating add/subtract unit, one attribute per cycle. It raises a sticky `morto` flag when any attribute reaches 0.

## Interface
- `TICK_W`, 22: prescaler width. One tick every 2^TICK_W cycles. Must be ≥ 3.
- `DELTA_UP`, 8'd8: increment applied to the attribute being replenished.
- `DELTA_DOWN`, 8'd1: decay applied per tick.
- `INIT`, 8'd128: reset value of every attribute.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `estado`, input, 4: one-hot state from `controlador_estados`. IDLE=0000, DORMINDO=0001, COMENDO=0010, DANDO_AULA=0100, MORTO=1000.
- `fome`, output, 8: satiety. 0 = starving.
- `felicidade`, output, 8: happiness.
- `sono`, output, 8: rest. 0 = exhausted.
- `morto`, output, 1: sticky death flag.
- `atualizado`, output, 1: one-cycle pulse when a tick's update sequence completes.

## Operation
- Reset (`rst_n`=0 at a clk edge) produces these values, and it overrides everything, including an update sequence in progress:
  - `fome` = `felicidade` = `sono` = INIT
  - prescaler = 0, FSM = ESPERA, `morto` = 0, `atualizado` = 0.
- Prescaler free-runs and wraps. `tick` = (prescaler == all ones).
- FSM states: ESPERA → UPD_FOME → UPD_FELIC → UPD_SONO → FIM → ESPERA.
  - ESPERA advances only on `tick` with `morto`=0.
  - All other transitions are unconditional.
- On leaving ESPERA, `estado` is latched into `estado_lat`. Changes to `estado` during the sequence have no effect until the next tick.
- Delta per attribute, selected by `estado_lat`:
  - IDLE: all three −DELTA_DOWN.
  - COMENDO: `fome` +DELTA_UP; `felicidade` and `sono` −DELTA_DOWN.
  - DORMINDO: `sono` +DELTA_UP; `fome` and `felicidade` −DELTA_DOWN.
  - DANDO_AULA: `felicidade` +DELTA_UP; `fome` −DELTA_DOWN; `sono` −2·DELTA_DOWN.
  - MORTO, or any non-one-hot code: no change to any attribute. The sequence still runs and `atualizado` still pulses.
- Arithmetic: computed at 9 bits, then saturated to the range [0, 255]. No wrap-around in either direction.
- Death check in FIM: if any attribute == 0, set `morto`. `morto` stays set until reset. While `morto`=1, ticks are ignored and attributes are frozen.
- A tick that arrives while the FSM is not in ESPERA is dropped. This cannot occur when TICK_W ≥ 3.

## Timing
- Let T be the cycle in which `tick`=1 and the FSM is in ESPERA.
- Edge ending T: latch `estado`; FSM moves to UPD_FOME.
- New `fome` visible from T+2, `felicidade` from T+3, `sono` from T+4.
- `atualizado` = 1 during T+4 (FIM) only.
- `morto` visible from T+5 when the condition holds.
- Latency from tick to all attributes updated: 4 cycles.
- All outputs are registered; no combinational path from `estado` to any output.

## Structure
- Package `tamagotchi_pkg` holds:
  - the `estado` localparams (IDLE, DORMINDO, COMENDO, DANDO_AULA, MORTO), shared with `controlador_estados`
  - attribute width `ATTR_W` = 8
  - the FSM state encoding.
- Sub-module `atualizador_saturado`: combinational shared unit. Inputs: 8-bit value, 9-bit magnitude, op (add/sub). Output: saturated 8-bit result.
- Top level holds the prescaler, FSM, `estado_lat`, the attribute registers and the operand muxes.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → `fome`/`felicidade`/`sono` = 128, `morto`=0, `atualizado`=0.
- TICK_W=4, `estado`=IDLE:
  - first tick → 127/127/127 at T+2/T+3/T+4
  - `atualizado` high exactly at T+4.
- `estado`=COMENDO, `fome` preloaded to 250 through repeated ticks:
  - next tick → `fome`=255 (saturated)
  - following tick → `fome` stays 255.
- `estado`=DANDO_AULA, `sono`=1 → `sono`=0 (saturated, not 255), `morto`=1 at T+5.
  - Further ticks leave all values and `morto` unchanged.
- Switch `estado` IDLE→DORMINDO at T+2 → the current sequence applies IDLE deltas; the next tick applies DORMINDO deltas.
- Assert `rst_n`=0 at T+2 (mid-sequence) → all attributes = 128, FSM = ESPERA, no `atualizado` pulse.

Source files
------------

// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the pet's state controller and attribute scheduler.
// Holds the estado codes, attribute width and scheduler FSM encoding.
package tamagotchi_pkg;

  localparam int ATTR_W = 8;

  localparam logic [3:0] IDLE       = 4'b0000;
  localparam logic [3:0] DORMINDO   = 4'b0001;
  localparam logic [3:0] COMENDO    = 4'b0010;
  localparam logic [3:0] DANDO_AULA = 4'b0100;
  localparam logic [3:0] MORTO      = 4'b1000;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    ESPERA,
    UPD_FOME,
    UPD_FELIC,
    UPD_SONO,
    FIM
  } fase_t;

endpackage

// File: rtl/atualizador_saturado.sv
// Shared saturating add/subtract unit, clamps the result to [0, 255].
// Purely combinational; one attribute passes through it per cycle.
module atualizador_saturado
  import tamagotchi_pkg::*;
(
  input  logic [ATTR_W-1:0] valor,
  input  logic [ATTR_W:0]   magnitude,
  input  logic              op,
  output logic [ATTR_W-1:0] resultado
);

  logic [ATTR_W+1:0] soma;

  always_comb begin
    soma      = {2'b00, valor} + {1'b0, magnitude};
    resultado = valor;
    if (op == OP_SUB) begin
      if (magnitude > {1'b0, valor})
        resultado = '0;
      else
        resultado = valor - magnitude[ATTR_W-1:0];
    end else begin
      if (soma[ATTR_W+1:ATTR_W] != 2'b00)
        resultado = '1;
      else
        resultado = soma[ATTR_W-1:0];
    end
  end

endmodule

// File: rtl/escalonador_atributos.sv
// Periodic attribute scheduler: every tick applies estado to fome,
// felicidade and sono, one attribute per cycle through a shared unit.
module escalonador_atributos
  import tamagotchi_pkg::*;
#(
  parameter int                TICK_W     = 22,
  parameter logic [ATTR_W-1:0] DELTA_UP   = 8'd8,
  parameter logic [ATTR_W-1:0] DELTA_DOWN = 8'd1,
  parameter logic [ATTR_W-1:0] INIT       = 8'd128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        estado,
  output logic [ATTR_W-1:0] fome,
  output logic [ATTR_W-1:0] felicidade,
  output logic [ATTR_W-1:0] sono,
  output logic              morto,
  output logic              atualizado
);

  logic [TICK_W-1:0] prescaler;
  logic              tick;
  fase_t             fase;
  fase_t             fase_prox;
  logic [3:0]        estado_lat;

  logic [ATTR_W-1:0] valor;
  logic [ATTR_W:0]   magnitude;
  logic              op;
  logic [ATTR_W-1:0] resultado;
  logic              valido;
  fase_t             alvo;
  logic              sobe;
  logic              dobro;

  assign tick = &prescaler;

  always_comb begin
    fase_prox = fase;
    unique case (fase)
      ESPERA:    if (tick && !morto) fase_prox = UPD_FOME;
      UPD_FOME:  fase_prox = UPD_FELIC;
      UPD_FELIC: fase_prox = UPD_SONO;
      UPD_SONO:  fase_prox = FIM;
      FIM:       fase_prox = ESPERA;
      default:   fase_prox = ESPERA;
    endcase
  end

  // alvo is the phase whose attribute gets replenished
  always_comb begin
    valido = 1'b1;
    alvo   = ESPERA;
    unique case (1'b1)
      (estado_lat == IDLE):       alvo = ESPERA;
      (estado_lat == COMENDO):    alvo = UPD_FOME;
      (estado_lat == DANDO_AULA): alvo = UPD_FELIC;
      (estado_lat == DORMINDO):   alvo = UPD_SONO;
      default:                    valido = 1'b0;
    endcase
  end

  always_comb begin
    sobe  = (alvo != ESPERA) && (fase == alvo);
    dobro = (estado_lat == DANDO_AULA) && (fase == UPD_SONO);
    op    = sobe ? OP_ADD : OP_SUB;
    if (!valido)
      magnitude = '0;
    else if (sobe)
      magnitude = {1'b0, DELTA_UP};
    else if (dobro)
      magnitude = {DELTA_DOWN, 1'b0};
    else
      magnitude = {1'b0, DELTA_DOWN};
  end

  always_comb begin
    valor = fome;
    unique case (fase)
      UPD_FELIC: valor = felicidade;
      UPD_SONO:  valor = sono;
      default:   valor = fome;
    endcase
  end

  atualizador_saturado u_atualizador (
    .valor     (valor),
    .magnitude (magnitude),
    .op        (op),
    .resultado (resultado)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler  <= '0;
      fase       <= ESPERA;
      estado_lat <= IDLE;
      fome       <= INIT;
      felicidade <= INIT;
      sono       <= INIT;
      morto      <= 1'b0;
      atualizado <= 1'b0;
    end else begin
      prescaler  <= prescaler + TICK_W'(1);
      fase       <= fase_prox;
      atualizado <= (fase_prox == FIM);
      if (fase == ESPERA && fase_prox == UPD_FOME)
        estado_lat <= estado;
      unique case (fase)
        UPD_FOME:  fome       <= resultado;
        UPD_FELIC: felicidade <= resultado;
        UPD_SONO:  sono       <= resultado;
        FIM: begin
          if (fome == '0 || felicidade == '0 || sono == '0)
            morto <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_atributos.sv
// Scoreboard bench for escalonador_atributos with a 16-cycle tick.
// Stimulus pushes expected attributes; a monitor checks each update pulse.
module tb_escalonador_atributos;
  import tamagotchi_pkg::*;

  typedef struct {
    logic [7:0] f;
    logic [7:0] h;
    logic [7:0] s;
    logic       m;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] estado;
  logic [7:0] fome;
  logic [7:0] felicidade;
  logic [7:0] sono;
  logic       morto;
  logic       atualizado;

  logic [31:0] cyc;
  exp_t        q[$];
  int          vectors;
  int          miscompares;
  int          mf, mh, ms;
  bit          mm;

  escalonador_atributos #(
    .TICK_W     (4),
    .DELTA_UP   (8'd8),
    .DELTA_DOWN (8'd1),
    .INIT       (8'd128)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .estado     (estado),
    .fome       (fome),
    .felicidade (felicidade),
    .sono       (sono),
    .morto      (morto),
    .atualizado (atualizado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc mirrors the prescaler value during each cycle
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cyc[3:0] != p[3:0] && n < 64);
    if (cyc[3:0] != p[3:0]) chk("phase_timeout", cyc[3:0], p[3:0]);
  endtask

  function automatic int sat(input int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic model(input logic [3:0] e);
    case (e)
      IDLE: begin
        mf = sat(mf - 1); mh = sat(mh - 1); ms = sat(ms - 1);
      end
      COMENDO: begin
        mf = sat(mf + 8); mh = sat(mh - 1); ms = sat(ms - 1);
      end
      DORMINDO: begin
        mf = sat(mf - 1); mh = sat(mh - 1); ms = sat(ms + 8);
      end
      DANDO_AULA: begin
        mf = sat(mf - 1); mh = sat(mh + 8); ms = sat(ms - 2);
      end
      default: ;
    endcase
    mm = (mf == 0) || (mh == 0) || (ms == 0);
  endtask

  task automatic push_exp();
    exp_t e;
    e.f = 8'(mf);
    e.h = 8'(mh);
    e.s = 8'(ms);
    e.m = mm;
    q.push_back(e);
  endtask

  task automatic tick(input logic [3:0] e, input bit sw,
                      input logic [3:0] e2);
    wait_phase(14);
    estado = e;
    model(e);
    push_exp();
    wait_phase(1);
    if (sw) estado = e2;
    wait_phase(4);
  endtask

  // monitor: checks every update pulse against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && atualizado === 1'b1) begin
        if (q.size() == 0) begin
          chk("pulse_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk("mon_fome", fome, e.f);
          chk("mon_felicidade", felicidade, e.h);
          chk("mon_sono", sono, e.s);
          @(negedge clk);
          chk("mon_morto", morto, e.m);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    estado      = IDLE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mf = 128; mh = 128; ms = 128; mm = 0;
    chk("rst_fome", fome, 128);
    chk("rst_felicidade", felicidade, 128);
    chk("rst_sono", sono, 128);
    chk("rst_morto", morto, 0);
    chk("rst_atualizado", atualizado, 0);

    // first tick, IDLE, cycle-exact visibility
    wait_phase(14);
    estado = IDLE;
    model(IDLE);
    push_exp();
    wait_phase(0);
    chk("t1_fome_old", fome, 128);
    wait_phase(1);
    chk("t2_fome", fome, 127);
    chk("t2_felic_old", felicidade, 128);
    wait_phase(2);
    chk("t3_felic", felicidade, 127);
    chk("t3_sono_old", sono, 128);
    chk("t3_atualizado", atualizado, 0);
    wait_phase(3);
    chk("t4_sono", sono, 127);
    chk("t4_atualizado", atualizado, 1);
    wait_phase(4);
    chk("t5_atualizado", atualizado, 0);

    // estado change mid-sequence only affects the next tick
    tick(IDLE, 1'b1, DORMINDO);
    chk("sw_sono_idle", sono, 126);
    tick(DORMINDO, 1'b0, IDLE);
    chk("sw_sono_dorm", sono, 134);
    chk("sw_fome_dorm", fome, 125);

    // reset in the middle of an update sequence
    wait_phase(14);
    estado = IDLE;
    wait_phase(1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mf = 128; mh = 128; ms = 128; mm = 0;
    chk("mid_rst_fome", fome, 128);
    chk("mid_rst_felicidade", felicidade, 128);
    chk("mid_rst_sono", sono, 128);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst_no_pulse", atualizado, 0);
    end

    // preload fome to 250, then saturate high
    for (int i = 0; i < 6; i++)  tick(IDLE, 1'b0, IDLE);
    for (int i = 0; i < 16; i++) tick(COMENDO, 1'b0, COMENDO);
    chk("pre_fome", fome, 250);
    tick(COMENDO, 1'b0, COMENDO);
    chk("sat_fome", fome, 255);
    tick(COMENDO, 1'b0, COMENDO);
    chk("sat_fome_hold", fome, 255);
    chk("sat_sono", sono, 104);

    // walk sono down to 1, then saturate low and die
    tick(IDLE, 1'b0, IDLE);
    for (int i = 0; i < 51; i++) tick(DANDO_AULA, 1'b0, DANDO_AULA);
    chk("pre_sono", sono, 1);
    chk("pre_morto", morto, 0);
    chk("pre_felic_sat", felicidade, 255);
    tick(DANDO_AULA, 1'b0, DANDO_AULA);
    chk("die_sono", sono, 0);
    chk("die_morto", morto, 1);

    // ticks after death change nothing
    estado = COMENDO;
    for (int i = 0; i < 3; i++) begin
      wait_phase(14);
      wait_phase(4);
    end
    chk("dead_fome", fome, 202);
    chk("dead_felicidade", felicidade, 255);
    chk("dead_sono", sono, 0);
    chk("dead_morto", morto, 1);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
